// File: rtl/gpif_arbiter.sv
// gpif_arbiter
//   Shares one GPIF-II write port between a streaming writer and a small
//   event-packet FIFO. The stream owns the port by default. An event is sent
//   only when the stream sits at a DMA boundary. Its words go out on thread
//   EVT_ADDR as one packet ending with pktend. A short gap follows before the
//   stream gets the port back.
//
//   Ports
//     clk, reset_n           single clock, asynchronous active-low reset
//     i_strm_idle            stream writer has no packet in progress
//     i_strm_slwr_n,
//     i_strm_pktend_n,
//     iv_strm_fifoaddr,
//     iv_strm_data           stream writer's GPIF signals (passed through)
//     o_strm_gnt             stream writer currently owns the GPIF port
//     i_evt_req              event FIFO (first-word-fall-through) non-empty
//     iv_evt_len             word count of the head event (0 is ignored)
//     iv_evt_data            head word of the event FIFO
//     o_evt_rd               pops one event word
//     o_evt_done             one-cycle pulse when an event packet has ended
//     i_usb_flagb            GPIF thread ready flag (high = ready)
//     ov_usb_fifoaddr,
//     o_usb_slwr_n,
//     o_usb_pktend_n,
//     ov_usb_data            registered GPIF outputs
//
//   Optional feature (macro GPIF_ARB_EVT_TIMEOUT_EN)
//     When defined, an event stuck waiting for flagb for 65535 cycles is popped
//     and thrown away without being written, and o_evt_done still pulses.
//     When undefined, the arbiter waits for flagb indefinitely.

module gpif_arbiter #(
   parameter int         DATA_WD    = 32,
   parameter logic [1:0] EVT_ADDR   = 2'b01,
   parameter int         EVT_LEN_WD = 5,
   parameter int         GAP_CYC    = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_strm_idle,
   input  logic                  i_strm_slwr_n,
   input  logic                  i_strm_pktend_n,
   input  logic [1:0]            iv_strm_fifoaddr,
   input  logic [DATA_WD-1:0]    iv_strm_data,
   output logic                  o_strm_gnt,
   input  logic                  i_evt_req,
   input  logic [EVT_LEN_WD-1:0] iv_evt_len,
   input  logic [DATA_WD-1:0]    iv_evt_data,
   output logic                  o_evt_rd,
   output logic                  o_evt_done,
   input  logic                  i_usb_flagb,
   output logic [1:0]            ov_usb_fifoaddr,
   output logic                  o_usb_slwr_n,
   output logic                  o_usb_pktend_n,
   output logic [DATA_WD-1:0]    ov_usb_data
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] STRM     = 3'd1;
   localparam logic [2:0] EVT_FLAG = 3'd2;
   localparam logic [2:0] EVT_WR   = 3'd3;
   localparam logic [2:0] EVT_END  = 3'd4;
   localparam logic [2:0] EVT_GAP  = 3'd5;

   localparam int GAP_WD = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   logic [2:0]            state;
   logic [2:0]            next_state;
   logic [EVT_LEN_WD-1:0] word_cnt;
   logic [GAP_WD-1:0]     gap_cnt;
   logic                  stream_side;
   logic                  evt_start;
   logic                  last_word;
   logic                  gap_last;
   logic                  pops_done;
   logic                  timeout;
   logic                  discard;

   assign stream_side = (state == IDLE) || (state == STRM);
   // An event may only start at a stream DMA boundary, and empty events are skipped.
   assign evt_start   = i_evt_req && i_strm_idle && (iv_evt_len != '0);
   assign last_word   = (state == EVT_WR) && (word_cnt == EVT_LEN_WD'(1));
   assign gap_last    = (gap_cnt == GAP_WD'(GAP_CYC - 1));

   assign o_strm_gnt  = stream_side;
   // Normal words are popped in EVT_WR. A timed-out event is drained during the gap.
   assign o_evt_rd    = (state == EVT_WR) ||
                        ((state == EVT_GAP) && discard && (word_cnt != '0));
   assign pops_done   = (word_cnt == '0) || (o_evt_rd && (word_cnt == EVT_LEN_WD'(1)));

`ifdef GPIF_ARB_EVT_TIMEOUT_EN
   logic [15:0] flag_wait;

   assign timeout = (state == EVT_FLAG) && !i_usb_flagb && (flag_wait == 16'hFFFF);

   // Counts how long flagb has been low while an event waits. Once it expires,
   // the event is marked for discard until the arbiter is back in IDLE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flag_wait <= '0;
         discard   <= 1'b0;
      end else begin
         if ((state == EVT_FLAG) && !i_usb_flagb && !timeout) begin
            flag_wait <= flag_wait + 16'd1;
         end else begin
            flag_wait <= '0;
         end
         if (timeout) begin
            discard <= 1'b1;
         end else if ((state == EVT_GAP) && (next_state == IDLE)) begin
            discard <= 1'b0;
         end
      end
   end
`else
   assign timeout = 1'b0;
   assign discard = 1'b0;
`endif

   // Next-state logic. If stream-idle and an event request arrive together,
   // the event wins. The single IDLE cycle after every gap gives the stream a
   // granted cycle before the next event can start.
   always_comb begin
      next_state = state;
      case (state)
         IDLE, STRM: begin
            if (evt_start) begin
               next_state = EVT_FLAG;
            end else if (!i_strm_idle) begin
               next_state = STRM;
            end else begin
               next_state = IDLE;
            end
         end
         EVT_FLAG: begin
            if (i_usb_flagb) begin
               next_state = EVT_WR;
            end else if (timeout) begin
               next_state = EVT_GAP;
            end
         end
         EVT_WR: begin
            if (last_word) begin
               next_state = EVT_END;
            end
         end
         EVT_END: next_state = EVT_GAP;
         EVT_GAP: begin
            if (gap_last && pops_done) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // State register and counters. The word counter is loaded when the event
   // leaves EVT_FLAG and counts pops. The gap counter runs only in EVT_GAP.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         word_cnt   <= '0;
         gap_cnt    <= '0;
         o_evt_done <= 1'b0;
      end else begin
         state <= next_state;
         if ((state == EVT_FLAG) && (i_usb_flagb || timeout)) begin
            word_cnt <= iv_evt_len;
         end else if (o_evt_rd) begin
            word_cnt <= word_cnt - EVT_LEN_WD'(1);
         end
         if (state == EVT_GAP) begin
            if (!gap_last) begin
               gap_cnt <= gap_cnt + GAP_WD'(1);
            end
         end else begin
            gap_cnt <= '0;
         end
         o_evt_done <= last_word || timeout;
      end
   end

   // GPIF output registers. Whenever the stream will own the port next cycle,
   // its signals are copied through with one cycle of latency. This also
   // restores the stream's fifoaddr on the way out of the gap. Otherwise the
   // event drives its thread address. A word popped in EVT_WR is written on the
   // following cycle, and the last word carries pktend.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ov_usb_fifoaddr <= 2'b00;
         o_usb_slwr_n    <= 1'b1;
         o_usb_pktend_n  <= 1'b1;
         ov_usb_data     <= '0;
      end else if ((next_state == IDLE) || (next_state == STRM)) begin
         ov_usb_fifoaddr <= iv_strm_fifoaddr;
         o_usb_slwr_n    <= i_strm_slwr_n;
         o_usb_pktend_n  <= i_strm_pktend_n;
         ov_usb_data     <= iv_strm_data;
      end else begin
         ov_usb_fifoaddr <= EVT_ADDR;
         o_usb_slwr_n    <= (state != EVT_WR);
         o_usb_pktend_n  <= !last_word;
         ov_usb_data     <= (state == EVT_WR) ? iv_evt_data : '0;
      end
   end

endmodule

// File: doc/gpif_arbiter.md
GPIF_ARBITER -- requirements
Module: gpif_arbiter

Interface
REQ-001 Parameter DATA_WD, default 32, GPIF data width.
REQ-002 Parameter EVT_ADDR, default 2'b01, GPIF thread address for event packets.
REQ-003 Parameter EVT_LEN_WD, default 5, event length field width in 32-bit words (max 31).
REQ-004 Parameter GAP_CYC, default 3, idle cycles after any pktend before flagb is trusted again.
REQ-005 Port clk  input  1  single clock, same frequency and phase as the GPIF clock; the only clock of the block.
REQ-006 Port reset_n  input  1  asynchronous, active-low reset.
REQ-007 Port i_strm_idle  input  1  stream writer is at a DMA boundary with no packet in progress.
REQ-008 Port i_strm_slwr_n / i_strm_pktend_n  input  1 each  stream writer's GPIF strobes.
REQ-009 Port iv_strm_fifoaddr  input  2  stream writer's thread address.
REQ-010 Port iv_strm_data  input  DATA_WD  stream writer's data.
REQ-011 Port o_strm_gnt  output  1  stream writer owns the GPIF port.
REQ-012 Port i_evt_req  input  1  event FIFO (first-word-fall-through) is non-empty.
REQ-013 Port iv_evt_len  input  EVT_LEN_WD  word count of the head event.
REQ-014 Port iv_evt_data  input  DATA_WD  head word of the event FIFO.
REQ-015 Port o_evt_rd  output  1  pops one event word.
REQ-016 Port o_evt_done  output  1  one-cycle pulse when an event packet has ended.
REQ-017 Port i_usb_flagb  input  1  GPIF thread ready flag, high means ready.
REQ-018 Port ov_usb_fifoaddr  output  2  GPIF thread address.
REQ-019 Ports o_usb_slwr_n / o_usb_pktend_n  output  1 each  GPIF write and packet-end strobes, active-low.
REQ-020 Port ov_usb_data  output  DATA_WD  GPIF data.

Function
REQ-021 The block SHALL implement states IDLE, STRM, EVT_FLAG, EVT_WR, EVT_END and EVT_GAP.
REQ-022 All GPIF outputs SHALL be registered; in IDLE and STRM, stream inputs SHALL appear on the GPIF outputs with exactly 1-cycle latency.
REQ-023 o_strm_gnt SHALL be high in IDLE and STRM and low in every EVT_* state.
REQ-024 IDLE->EVT_FLAG and STRM->EVT_FLAG SHALL occur only when i_evt_req=1, i_strm_idle=1 and iv_evt_len!=0; event requests SHALL never preempt a packet in progress.
REQ-025 IDLE->STRM SHALL occur on i_strm_idle=0; STRM->IDLE SHALL occur on i_strm_idle=1.
REQ-026 If i_strm_idle=1 and i_evt_req=1 in the same cycle, the event SHALL win.
REQ-027 In EVT_FLAG, ov_usb_fifoaddr SHALL be EVT_ADDR, and the state SHALL move to EVT_WR when i_usb_flagb=1, latching iv_evt_len into a word counter.
REQ-028 In EVT_WR, o_evt_rd=1 and slwr_n=0 (registered) SHALL hold for exactly len cycles, with ov_usb_data = iv_evt_data delayed by 1 cycle.
REQ-029 EVT_END SHALL assert o_usb_pktend_n=0 for exactly 1 cycle, together with the last data word's slwr, and pulse o_evt_done.
REQ-030 EVT_GAP SHALL keep both strobes high for GAP_CYC cycles, then return to IDLE with ov_usb_fifoaddr restored to iv_strm_fifoaddr.
REQ-031 A len of 0 SHALL be ignored: no grant change and no pop.
REQ-032 After an event, the stream SHALL be granted for at least one cycle before the next event if i_strm_idle=0 (anti-starvation); back-to-back events are otherwise allowed.
REQ-033 While i_usb_flagb is low in EVT_FLAG, the block SHALL wait indefinitely unless the timeout feature is compiled in.

Reset
REQ-034 While reset_n=0, the state SHALL be IDLE, o_usb_slwr_n=1, o_usb_pktend_n=1, ov_usb_fifoaddr=0, ov_usb_data=0, o_strm_gnt=1, o_evt_rd=0, o_evt_done=0, and all counters 0.
REQ-035 Reset asserted mid-event SHALL abandon the packet without issuing pktend; the partially popped event is lost.

Configuration
REQ-036 Macro GPIF_ARB_EVT_TIMEOUT_EN: when defined, a 16-bit counter SHALL count cycles in EVT_FLAG with flagb=0. At 16'hFFFF the block SHALL go to EVT_GAP, pop and discard the whole event (len pops, slwr held high), and pulse o_evt_done. When the macro is undefined, the counter SHALL not exist and REQ-033 applies.

Verification
REQ-037 Stream only, i_evt_req=0, 8192-word burst -> GPIF outputs equal stream inputs delayed 1 cycle; o_strm_gnt constantly 1.
REQ-038 Event len=4 arrives while i_strm_idle=0 -> no grant until i_strm_idle=1; then fifoaddr=2'b01, 4 slwr, pktend coincident with the 4th word, 3 gap cycles, then IDLE.
REQ-039 Event pending and flagb held low 50 cycles -> no slwr during the hold; writes start 1 cycle after flagb rises.
REQ-040 Simultaneous i_strm_idle=1 and i_evt_req=1 with len=1 -> event wins; a single-word packet with slwr and pktend in the same cycle.
REQ-041 reset_n pulsed low during EVT_WR word 2 of 6 -> all outputs at reset values asynchronously; no pktend issued.
REQ-042 With GPIF_ARB_EVT_TIMEOUT_EN defined and flagb stuck low -> after 65535 cycles the event is discarded, o_evt_done pulses once, and the stream resumes.
